// File: rtl/stack_unit.sv
// stack_unit: hardware operand stack for the multicycle stack-machine datapath.
// Executes one push/pop command per cycle. It presents top-of-stack and
// next-on-stack combinationally and tracks depth. Overflow and underflow are
// reported through sticky flags.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears count, flags and storage
//   push       write push_data as the new top this cycle
//   pop        remove the current top this cycle (push+pop replaces the top)
//   push_data  value to push
//   clear_err  synchronous clear of the sticky error flags
//   tos        current top entry, 0 when empty
//   nos        entry below the top, 0 when count < 2
//   tos_zero   tos == 0 (also high when empty)
//   count      number of valid entries, 0..DEPTH
//   empty      count == 0
//   full       count == DEPTH
//   overflow   sticky: a push was rejected because the stack was full
//   underflow  sticky: a pop was attempted while the stack was empty
module stack_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     clear_err,
    output logic [WIDTH-1:0]         tos,
    output logic [WIDTH-1:0]         nos,
    output logic                     tos_zero,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] top_idx;
    logic [AW-1:0] nos_idx;
    logic          we;
    logic [AW-1:0] waddr;
    logic [CW-1:0] count_nxt;
    logic          ovf_evt;
    logic          unf_evt;

    // Indices wrap harmlessly when count is 0 or 1; the results are masked below.
    assign top_idx  = AW'(count - CW'(1));
    assign nos_idx  = AW'(count - CW'(2));

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign tos      = empty ? '0 : mem[top_idx];
    assign nos      = (count < CW'(2)) ? '0 : mem[nos_idx];
    assign tos_zero = (tos == '0);

    always_comb begin
        we        = 1'b0;
        waddr     = '0;
        count_nxt = count;
        ovf_evt   = 1'b0;
        unf_evt   = 1'b0;
        unique case ({push, pop})
            2'b10: begin
                if (full) begin
                    ovf_evt = 1'b1;
                end else begin
                    we        = 1'b1;
                    waddr     = AW'(count);
                    count_nxt = count + CW'(1);
                end
            end
            2'b01: begin
                if (empty) unf_evt = 1'b1;
                else       count_nxt = count - CW'(1);
            end
            2'b11: begin
                we = 1'b1;
                if (empty) begin
                    // Pop fails, but the push half still lands as the sole entry.
                    unf_evt   = 1'b1;
                    waddr     = '0;
                    count_nxt = CW'(1);
                end else begin
                    waddr = top_idx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            count <= count_nxt;
            if (we) mem[waddr] <= push_data;
            // A new error event takes priority over clear_err in the same cycle.
            if (ovf_evt)        overflow <= 1'b1;
            else if (clear_err) overflow <= 1'b0;
            if (unf_evt)        underflow <= 1'b1;
            else if (clear_err) underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stack_unit.sv
module tb_stack_unit;

    localparam int unsigned W = 8;
    localparam int unsigned D = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         push, pop, clear_err;
    logic [W-1:0] push_data;
    logic [W-1:0] tos, nos;
    logic         tos_zero, empty, full, overflow, underflow;
    logic [4:0]   count;

    int checks = 0;
    int errors = 0;

    stack_unit #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop),
        .push_data(push_data), .clear_err(clear_err),
        .tos(tos), .nos(nos), .tos_zero(tos_zero), .count(count),
        .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Reference model: a queue holding exactly the valid entries, bottom first.
    logic [W-1:0] q[$];
    logic         m_ovf, m_unf;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            bit ev_o, ev_u;
            ev_o = 1'b0;
            ev_u = 1'b0;
            if (push && !pop) begin
                if (q.size() < D) q.push_back(push_data);
                else ev_o = 1'b1;
            end else if (pop && !push) begin
                if (q.size() > 0) void'(q.pop_back());
                else ev_u = 1'b1;
            end else if (push && pop) begin
                if (q.size() > 0) q[q.size()-1] = push_data;
                else begin
                    q.push_back(push_data);
                    ev_u = 1'b1;
                end
            end
            m_ovf = ev_o ? 1'b1 : (clear_err ? 1'b0 : m_ovf);
            m_unf = ev_u ? 1'b1 : (clear_err ? 1'b0 : m_unf);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            logic [W-1:0] e_tos, e_nos;
            int n;
            n     = q.size();
            e_tos = (n >= 1) ? q[n-1] : '0;
            e_nos = (n >= 2) ? q[n-2] : '0;
            chk("m_count", 32'(count), 32'(n));
            chk("m_tos", 32'(tos), 32'(e_tos));
            chk("m_nos", 32'(nos), 32'(e_nos));
            chk("m_tos_zero", 32'(tos_zero), 32'(e_tos == '0));
            chk("m_empty", 32'(empty), 32'(n == 0));
            chk("m_full", 32'(full), 32'(n == D));
            chk("m_overflow", 32'(overflow), 32'(m_ovf));
            chk("m_underflow", 32'(underflow), 32'(m_unf));
        end
    end

    // Apply one command for one clock, then sample #1 after the edge.
    task automatic step(input logic p, input logic o, input logic [W-1:0] d, input logic c);
        push = p; pop = o; push_data = d; clear_err = c;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clear_err = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; clear_err = 1'b0; push_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_tos", 32'(tos), 0);
        chk("rst_tos_zero", 32'(tos_zero), 1);
        chk("rst_count", 32'(count), 0);
        reset = 1'b0;

        // Push/pop basics
        step(1, 0, 8'h05, 0);
        step(1, 0, 8'h0A, 0);
        chk("pp_count", 32'(count), 2);
        chk("pp_tos", 32'(tos), 32'h0A);
        chk("pp_nos", 32'(nos), 32'h05);
        step(0, 1, 8'h00, 0);
        chk("pop_count", 32'(count), 1);
        chk("pop_tos", 32'(tos), 32'h05);
        step(0, 1, 8'h00, 0);

        // Underflow, then a valid push with the flag still set
        step(0, 1, 8'h00, 0);
        chk("unf_flag", 32'(underflow), 1);
        chk("unf_count", 32'(count), 0);
        step(1, 0, 8'h03, 0);
        chk("unf_push_count", 32'(count), 1);
        chk("unf_push_tos", 32'(tos), 3);
        chk("unf_sticky", 32'(underflow), 1);
        step(0, 0, 8'h00, 1);
        chk("unf_clear", 32'(underflow), 0);

        // Asynchronous reset mid-stream with three entries
        step(1, 0, 8'h11, 0);
        step(1, 0, 8'h22, 0);
        chk("mid_count3", 32'(count), 3);
        #1 reset = 1'b1;
        #1;
        chk("async_count", 32'(count), 0);
        chk("async_tos", 32'(tos), 0);
        chk("async_nos", 32'(nos), 0);
        chk("async_empty", 32'(empty), 1);
        chk("async_tos_zero", 32'(tos_zero), 1);
        #1 reset = 1'b0;

        // Fill to DEPTH, overflow, clear, replace-top when full
        for (int i = 1; i <= 16; i++) step(1, 0, 8'(i), 0);
        chk("fill_full", 32'(full), 1);
        chk("fill_tos", 32'(tos), 32'h10);
        step(1, 0, 8'hFF, 0);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 16);
        chk("ovf_tos", 32'(tos), 32'h10);
        step(0, 0, 8'h00, 1);
        chk("ovf_clear", 32'(overflow), 0);
        step(1, 1, 8'hEE, 0);
        chk("full_rep_tos", 32'(tos), 32'hEE);
        chk("full_rep_nos", 32'(nos), 32'h0F);
        chk("full_rep_count", 32'(count), 16);
        chk("full_rep_ovf", 32'(overflow), 0);

        // Replace top on [0x05,0x0A]
        do_reset();
        step(1, 0, 8'h05, 0);
        step(1, 0, 8'h0A, 0);
        step(1, 1, 8'h0F, 0);
        chk("rep_tos", 32'(tos), 32'h0F);
        chk("rep_nos", 32'(nos), 32'h05);
        chk("rep_count", 32'(count), 2);
        chk("rep_unf", 32'(underflow), 0);

        // Push+pop on empty
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 0);
        step(1, 1, 8'h07, 0);
        chk("pp_empty_count", 32'(count), 1);
        chk("pp_empty_tos", 32'(tos), 32'h07);
        chk("pp_empty_unf", 32'(underflow), 1);

        // Zero test
        step(1, 0, 8'h00, 0);
        chk("tz_one", 32'(tos_zero), 1);
        chk("tz_count", 32'(count), 2);
        step(1, 0, 8'h01, 0);
        chk("tz_zero", 32'(tos_zero), 0);

        // Error event wins over clear_err in the same cycle
        step(0, 0, 8'h00, 1);
        chk("clr_unf", 32'(underflow), 0);
        for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0);
        chk("drain_count", 32'(count), 0);
        step(0, 1, 8'h00, 1);
        chk("evt_wins", 32'(underflow), 1);
        chk("evt_count", 32'(count), 0);

        step(0, 0, 8'h00, 0);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_unit.md
# stack_unit

Hardware operand stack for the multicycle stack-machine datapath; it executes the push/pop requests that the control FSM issues each cycle. It presents the top-of-stack and next-on-stack combinationally, so the controller can pop into its operand registers, and it supplies the zero test for conditional jumps. It also tracks depth and flags overflow and underflow.

## Interface
Parameters:
- WIDTH, 8, data word width in bits
- DEPTH, 16, number of entries; must be a power of two and at least 2

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high
- push  input  1  write push_data as the new top this cycle
- pop  input  1  remove the current top this cycle
- push_data  input  WIDTH  value to push; the datapath muxes ALU or MDR into it upstream
- clear_err  input  1  synchronous clear of the sticky error flags
- tos  output  WIDTH  current top entry; 0 when empty
- nos  output  WIDTH  entry below the top; 0 when count < 2
- tos_zero  output  1  high when tos == 0, including when empty
- count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- overflow  output  1  sticky; a push was rejected because the stack was full
- underflow  output  1  sticky; a pop was attempted while the stack was empty

## Operation
- Storage is DEPTH x WIDTH registers plus a pointer count. The valid entries are mem[0..count-1], and the top is mem[count-1].
- tos, nos, tos_zero, empty and full are combinational from the registered state.
- Because the read is combinational, a value popped in cycle N is on tos during cycle N, and the consumer captures it at the same edge.
- Each cycle's command is {push,pop}:
  - 00: no change.
  - 10, not full: mem[count] <= push_data and count <= count+1.
  - 10, full: storage and count unchanged; overflow <= 1.
  - 01, not empty: count <= count-1. The data is not cleared; it becomes unreachable.
  - 01, empty: no change; underflow <= 1.
  - 11, not empty: replace the top, mem[count-1] <= push_data, with count unchanged. This holds even when full, and neither flag is set.
  - 11, empty: underflow <= 1; push_data is still written to mem[0] and count <= 1.
- Error flags:
  - overflow and underflow stay set until clear_err or reset.
  - When clear_err and a new error event occur in the same cycle, the new event wins and the flag stays set.
  - An error never blocks later valid commands.
- Arithmetic: count never wraps. It saturates at 0 and DEPTH through the rejection rules above.

## Timing
- Reset, asynchronous:
  - count = 0, overflow = 0, underflow = 0.
  - All mem entries = 0.
  - Therefore tos = 0, nos = 0, tos_zero = 1, empty = 1, full = 0.
- Reset asserted mid-sequence takes effect immediately, regardless of clk. The first command is accepted on the first rising edge after reset deasserts.
- Write latency is one cycle: after a push at edge N, tos = push_data from edge N until the next change.
- Read latency is zero: tos and nos follow count and mem with no register stage.
- There is no handshake and no back-pressure. Every command completes in the cycle it is presented, and rejected commands are reported only through the sticky flags.
- Only one storage entry is written per cycle.

## Test plan
- Reset then idle:
  - After reset, empty=1, tos=0, tos_zero=1, count=0.
  - Assert reset mid-stream with count=3: all outputs return to reset values before the next edge.
- Push 0x05 then 0x0A: count=2, tos=0x0A, nos=0x05. Then pop: count=1, tos=0x05, and tos=0x0A was visible during the pop cycle.
- Fill with DEPTH pushes 1..16:
  - full=1 and tos=0x10.
  - A 17th push of 0xFF gives overflow=1, count=16, tos=0x10.
  - clear_err gives overflow=0.
- Pop on empty: underflow=1 and count stays 0. A following push of 0x03 succeeds (count=1, tos=0x03) with underflow still 1.
- Simultaneous push+pop:
  - With stack [0x05,0x0A], push_data=0x0F gives tos=0x0F, nos=0x05, count=2.
  - On empty, push_data=0x07 gives count=1, tos=0x07, underflow=1.
  - When full, it replaces the top with no overflow.
- Jump-zero support: push 0x00 gives tos_zero=1; push 0x01 gives tos_zero=0. Also pop with clear_err and an underflow event in the same cycle gives underflow=1.
